// File: rtl/ram2pnr1wbe_clr.sv
// ram2pnr1wbe_clr: NRD-read/1-write byte-enabled SRAM with hold-until-next-read ports and a zeroing clear sequencer
// Ports: clk; reset_n async active-low; ce/ra/rd per read port (packed, port 0 in LSBs);
//        wce/we/wa/wd/bwe write port; clrreq starts a full clear; busy is high while clearing.
module ram2pnr1wbe_clr #(
  parameter int DEPTH    = 1024,
  parameter int WIDTH    = 68,
  parameter int NRD      = 2,
  parameter int RDW_MODE = 0,
  parameter int OUTREG   = 0,
  parameter int CLEAR    = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = (WIDTH - 1) / 8 + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NRD-1:0]       ce,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  input  logic                 wce,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [NB-1:0]        bwe,
  input  logic                 clrreq,
  output logic                 busy
);
  typedef enum logic {RUN, CLR} state_t;
  state_t st;
  logic [AW-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wmask;
  logic wen;
  assign busy = (st == CLR);
  assign wen = wce & we & ~busy;
  always_comb begin
    wmask = '0;
    for (int j = 0; j < WIDTH; j++) wmask[j] = bwe[j/8];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st  <= (CLEAR != 0) ? CLR : RUN;
      cnt <= '0;
    end else if (st == CLR) begin
      cnt <= cnt + 1'b1;
      st  <= (cnt == AW'(DEPTH - 1)) ? RUN : CLR;
    end else if (clrreq && CLEAR != 0) begin
      st  <= CLR;
      cnt <= '0;
    end
  // Array contents are deliberately not reset; the clear sequencer rewrites them.
  always_ff @(posedge clk)
    if (busy) mem[cnt] <= '0;
    else if (wen) mem[wa] <= (mem[wa] & ~wmask) | (wd & wmask);
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [WIDTH-1:0] q;
    assign a = ra[i*AW +: AW];
    // Reads sample the pre-write array; write-first mode merges the incoming lanes on an address match.
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q <= '0;
      else if (ce[i]) q <= busy ? '0 :
                          (RDW_MODE != 0 && wen && wa == a) ? (mem[a] & ~wmask) | (wd & wmask) : mem[a];
    if (OUTREG != 0) begin : g_o
      logic v;
      logic [WIDTH-1:0] o;
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          v <= 1'b0;
          o <= '0;
        end else begin
          v <= ce[i];
          if (v) o <= q;
        end
      assign rd[i*WIDTH +: WIDTH] = o;
    end else begin : g_n
      assign rd[i*WIDTH +: WIDTH] = q;
    end
  end
endmodule

// File: tb/tb_ram2pnr1wbe_clr.sv
// tb_ram2pnr1wbe_clr: checks a read-first/no-outreg instance and a write-first/outreg instance side by side
module tb_ram2pnr1wbe_clr;
  localparam int W = 68;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] H1 = {17{4'h1}};
  localparam logic [W-1:0] H2 = {17{4'h2}};
  logic clk = 1'b0, reset_n, wce, we, clrreq, busya, busyb, mon = 1'b0;
  logic [2:0] ce;
  logic [3:0] ra_a [3];
  logic [11:0] ra;
  logic [3:0] wa;
  logic [W-1:0] wd;
  logic [8:0] bwe;
  logic [3*W-1:0] rda, rdb;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign ra = {ra_a[2], ra_a[1], ra_a[0]};
  ram2pnr1wbe_clr #(.DEPTH(16), .WIDTH(W), .NRD(3), .RDW_MODE(0), .OUTREG(0), .CLEAR(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ra(ra), .rd(rda), .wce(wce), .we(we), .wa(wa),
    .wd(wd), .bwe(bwe), .clrreq(clrreq), .busy(busya));
  ram2pnr1wbe_clr #(.DEPTH(16), .WIDTH(W), .NRD(3), .RDW_MODE(1), .OUTREG(1), .CLEAR(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ra(ra), .rd(rdb), .wce(wce), .we(we), .wa(wa),
    .wd(wd), .bwe(bwe), .clrreq(clrreq), .busy(busyb));
  logic [W-1:0] m [16];
  logic [W-1:0] qa [3], qb [3], ob [3], mask, base;
  logic vp [3], mbusy, mwen;
  int cidx;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mbusy = 1'b1;
      cidx = 0;
      for (int p = 0; p < 3; p++) begin
        qa[p] = '0; qb[p] = '0; ob[p] = '0; vp[p] = 1'b0;
      end
    end else begin
      for (int j = 0; j < W; j++) mask[j] = bwe[j/8];
      mwen = wce && we && !mbusy;
      for (int p = 0; p < 3; p++) begin
        if (vp[p]) ob[p] = qb[p];
        vp[p] = ce[p];
        if (ce[p]) begin
          base = mbusy ? '0 : m[ra_a[p]];
          qa[p] = base;
          qb[p] = (mwen && wa == ra_a[p]) ? (base & ~mask) | (wd & mask) : base;
        end
      end
      if (mbusy) begin
        m[cidx] = '0;
        if (cidx == 15) mbusy = 1'b0;
        cidx++;
      end else begin
        if (mwen) m[wa] = (m[wa] & ~mask) | (wd & mask);
        if (clrreq) begin
          mbusy = 1'b1;
          cidx = 0;
        end
      end
    end
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    if (mon) begin
      check("busy_a", W'(busya), W'(mbusy));
      check("busy_b", W'(busyb), W'(mbusy));
      for (int p = 0; p < 3; p++) begin
        check("model_rd_a", rda[p*W +: W], qa[p]);
        check("model_rd_b", rdb[p*W +: W], ob[p]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ce = '0; wce = 1'b0; we = 1'b0; clrreq = 1'b0;
  endtask
  task automatic wr(input logic [3:0] a, input logic [W-1:0] d, input logic [8:0] be);
    wce = 1'b1; we = 1'b1; wa = a; wd = d; bwe = be;
    tick();
    idle();
  endtask
  task automatic count_busy(output int n);
    n = 0;
    while (busya === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask
  typedef struct {
    logic [3:0] wa; logic [W-1:0] wd; logic [8:0] bwe; logic we; logic [3:0] ra;
    logic [W-1:0] ea, eb;
  } vec_t;
  vec_t tv [9];
  int n;
  initial begin
    tv[0] = '{4'd5, ONES, 9'h1ff, 1'b1, 4'd5, '0, ONES};
    tv[1] = '{4'd5, '0, 9'h100, 1'b1, 4'd5, ONES, 68'h0_FFFF_FFFF_FFFF_FFFF};
    tv[2] = '{4'd5, '0, 9'h000, 1'b0, 4'd5, 68'h0_FFFF_FFFF_FFFF_FFFF, 68'h0_FFFF_FFFF_FFFF_FFFF};
    tv[3] = '{4'd5, '0, 9'h001, 1'b1, 4'd5, 68'h0_FFFF_FFFF_FFFF_FFFF, 68'h0_FFFF_FFFF_FFFF_FF00};
    tv[4] = '{4'd3, H1, 9'h1ff, 1'b1, 4'd3, '0, H1};
    tv[5] = '{4'd3, H2, 9'h1ff, 1'b1, 4'd3, H1, H2};
    tv[6] = '{4'd3, H1, 9'h1ff, 1'b1, 4'd3, H2, H1};
    tv[7] = '{4'd3, H2, 9'h001, 1'b1, 4'd3, H1, 68'h1_1111_1111_1111_1122};
    tv[8] = '{4'd3, '0, 9'h000, 1'b0, 4'd3, 68'h1_1111_1111_1111_1122, 68'h1_1111_1111_1111_1122};
    reset_n = 1'b0;
    idle();
    wa = '0; wd = '0; bwe = '0;
    for (int p = 0; p < 3; p++) ra_a[p] = '0;
    repeat (3) tick();
    mon = 1'b1;
    check("reset_rd", rdb, '0);
    check("reset_busy", W'(busyb), W'(1));
    reset_n = 1'b1;
    count_busy(n);
    check("busy_len_reset", W'(n), W'(16));
    for (int k = 0; k < 9; k++) begin
      wce = tv[k].we; we = tv[k].we; wa = tv[k].wa; wd = tv[k].wd; bwe = tv[k].bwe;
      for (int p = 0; p < 3; p++) ra_a[p] = tv[k].ra;
      ce = 3'b111;
      tick();
      idle();
      check("tv_rd_a", rda[W-1:0], tv[k].ea);
      tick();
      check("tv_hold_a", rda[W-1:0], tv[k].ea);
      check("tv_rd_b", rdb[W-1:0], tv[k].eb);
    end
    wr(4'd7, H1, 9'h1ff);
    ra_a[0] = 4'd7; ce = 3'b001;
    tick();
    idle();
    wr(4'd7, H2, 9'h1ff);
    check("hold_after_write", rda[W-1:0], H1);
    ce = 3'b001;
    tick();
    idle();
    check("hold_reread", rda[W-1:0], H2);
    wr(4'd1, 68'hA_5A5A_5A5A_5A5A_5A5A, 9'h1ff);
    wr(4'd2, 68'h3_C3C3_C3C3_C3C3_C3C3, 9'h1ff);
    ra_a[0] = 4'd1; ra_a[1] = 4'd2; ra_a[2] = 4'd1; ce = 3'b111;
    tick();
    idle();
    tick();
    check("mp_p0", rdb[0 +: W], 68'hA_5A5A_5A5A_5A5A_5A5A);
    check("mp_p1", rdb[W +: W], 68'h3_C3C3_C3C3_C3C3_C3C3);
    check("mp_p2", rdb[2*W +: W], 68'hA_5A5A_5A5A_5A5A_5A5A);
    check("mp_p0_eq_p2", rdb[0 +: W], rdb[2*W +: W]);
    for (int a = 0; a < 16; a++) wr(4'(a), ONES, 9'h1ff);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wce = 1'b1; we = 1'b1; wa = 4'd9; wd = ONES; bwe = 9'h1ff;
    count_busy(n);
    idle();
    check("busy_len_preload", W'(n), W'(16));
    for (int a = 0; a < 16; a++) begin
      ra_a[0] = 4'(a); ce = 3'b001;
      tick();
      check("zero_after_clear", rda[W-1:0], '0);
    end
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 3; p++) ra_a[p] = 4'($urandom_range(0, 15));
      ce = 3'($urandom); wce = 1'($urandom); we = 1'($urandom);
      wa = 4'($urandom_range(0, 15));
      wd = W'({$urandom, $urandom, $urandom});
      bwe = 9'($urandom);
      clrreq = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle();
    repeat (20) tick();
    for (int a = 0; a < 16; a++) wr(4'(a), H1 ^ W'(a), 9'h1ff);
    clrreq = 1'b1;
    tick();
    clrreq = 1'b0;
    count_busy(n);
    check("busy_len_clrreq", W'(n), W'(16));
    for (int a = 0; a < 16; a++) begin
      ra_a[1] = 4'(a); ce = 3'b010;
      tick();
      check("zero_after_clrreq", rda[W +: W], '0);
    end
    idle();
    clrreq = 1'b1;
    tick();
    clrreq = 1'b0;
    repeat (8) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    count_busy(n);
    check("busy_len_reset_mid_clear", W'(n), W'(16));
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
